acq_ctrl: RTL and testbench
===========================

ACQ_CTRL -- requirements
Module: acq_ctrl

Interface
REQ-001 Parameter LEN_W, default 16, width of the capture-length field and sample counter.
REQ-002 axi_aclk  in  1  sole clock; all logic on rising edge.
REQ-003 axi_areset  in  1  asynchronous, active-high reset.
REQ-004 cmd_axis_tvalid/tready/tdata/tlast  in/out/in/in  1/1/8/1  command byte stream from the SPI receiver.
REQ-005 adc_axis_tvalid/tready/tdata/tlast  in/out/in/in  1/1/8/1  sample stream from the ADC; tlast ignored.
REQ-006 out_axis_tvalid/tready/tdata/tlast  out/in/out/out  1/1/8/1  captured-sample stream to the SPI transmitter.
REQ-007 trigger  in  1  capture trigger, already synchronous to axi_aclk.
REQ-008 busy  out  1  high whenever state is not IDLE.
REQ-009 armed  out  1  high only in state ARM.

Function
REQ-010 FSM states: IDLE, ARM, CAPTURE; state is registered, and busy/armed are decoded from it.
REQ-011 cmd_axis_tready SHALL be 1 in every state once out of reset, so command bytes are never back-pressured.
REQ-012 Frame format in IDLE: exactly 3 bytes {opcode, len[15:8], len[7:0]}, with tlast on byte 3; len is truncated to LEN_W bits.
REQ-013 Frame byte counter 0..3 clears on every accepted tlast and on leaving IDLE.
REQ-014 Frames are discarded without effect if tlast arrives before byte 3, or if byte 3 lacks tlast; in the second case, bytes are dropped until the next tlast.
REQ-015 Valid frame, opcode 0x01 (immediate): state -> CAPTURE on the cycle after the tlast handshake.
REQ-016 Valid frame, opcode 0x02 (triggered): state -> ARM on the cycle after the tlast handshake.
REQ-017 Other opcodes: frame dropped, state stays IDLE.
REQ-018 len == 0 with opcode 0x01 or 0x02: no transition, no output beats.
REQ-019 Trigger edge detector: registered trigger_d; edge = trigger & ~trigger_d; evaluated every cycle but acted on only in ARM.
REQ-020 ARM + edge: state -> CAPTURE next cycle; a level held high on ARM entry does not fire (trigger_d already 1).
REQ-021 ARM + single-byte frame 0xFF with tlast: abort, state -> IDLE next cycle; all other bytes in ARM are discarded.
REQ-022 If an abort and a trigger edge occur in the same cycle, the abort wins.
REQ-023 All command bytes received in CAPTURE are discarded; a capture cannot be aborted.
REQ-024 In IDLE and ARM, adc_axis_tready = 1 and samples are dropped, so the ADC never stalls.
REQ-025 CAPTURE uses a one-entry registered output stage: adc_axis_tready = ~out_axis_tvalid | out_axis_tready, with 1-cycle latency from ADC handshake to out_axis_tvalid.
REQ-026 Sample counter (LEN_W bits) clears on CAPTURE entry and increments on each ADC handshake in CAPTURE.
REQ-027 When the counter reaches len, the sample is loaded with out_axis_tlast = 1, and adc_axis_tready is 0 for the rest of CAPTURE.
REQ-028 Exactly len beats are emitted per capture, and out_axis_tdata equals the accepted adc_axis_tdata in order.
REQ-029 Out-stage tvalid/tdata/tlast remain stable while out_axis_tready = 0 (AXI-Stream rules).
REQ-030 The out handshake with tlast = 1 causes state -> IDLE on the next cycle, with out_axis_tvalid deasserted.
REQ-031 len = 2^LEN_W-1 completes without counter overflow; the counter never wraps within a capture.

Reset
REQ-032 axi_areset asserted forces, asynchronously: state = IDLE, and all of the following to 0: counter, frame counter, trigger_d, out_axis_tvalid/tdata/tlast, busy, armed, cmd_axis_tready, adc_axis_tready.
REQ-033 After deassertion, cmd_axis_tready and adc_axis_tready rise on the first axi_aclk edge.
REQ-034 Reset mid-CAPTURE drops the pending out beat; no tlast is emitted for the truncated capture.

Verification
REQ-035 Frame {0x01,0x00,0x04}+tlast, ADC ramp 0x10.., out_tready = 1 -> out beats 0x10,0x11,0x12,0x13, tlast on 0x13, busy low 1 cycle after the last beat.
REQ-036 Frame {0x02,0x00,0x02}, trigger pulse after 20 cycles -> armed high for 20 cycles, then 2 beats of the samples taken after the edge, tlast on the 2nd.
REQ-037 Same capture with out_tready toggled 1/0 every cycle -> no lost or duplicated samples, and tdata stays stable while stalled.
REQ-038 Frames {0x01,0x00}+tlast, {0x03,0x00,0x05}+tlast, and {0x01,0x00,0x00}+tlast -> busy remains 0 and no out beats.
REQ-039 In ARM, send 0xFF+tlast in the same cycle as a trigger edge -> IDLE next cycle, no out beats.
REQ-040 Assert reset after 3 of 8 beats -> all outputs 0 immediately; a new {0x01,0x00,0x01} frame then yields exactly 1 beat with tlast.

Source files
------------

// File: rtl/acq_ctrl.sv
// acq_ctrl: command-driven ADC capture controller with immediate/triggered start and abort.
module acq_ctrl #(
  parameter int LEN_W = 16
) (
  input  logic       axi_aclk,
  input  logic       axi_areset,
  input  logic       cmd_axis_tvalid,
  output logic       cmd_axis_tready,
  input  logic [7:0] cmd_axis_tdata,
  input  logic       cmd_axis_tlast,
  input  logic       adc_axis_tvalid,
  output logic       adc_axis_tready,
  input  logic [7:0] adc_axis_tdata,
  input  logic       adc_axis_tlast,
  output logic       out_axis_tvalid,
  input  logic       out_axis_tready,
  output logic [7:0] out_axis_tdata,
  output logic       out_axis_tlast,
  input  logic       trigger,
  output logic       busy,
  output logic       armed
);
  typedef enum logic [1:0] {IDLE, ARM, CAPTURE} state_t;
  state_t state, state_nx;
  logic rdy, trig_d, drop, adc_unused;
  logic [1:0] fcnt;
  logic [7:0] opc, len_hi;
  logic [LEN_W-1:0] len, cnt, len_new;
  logic cmd_hs, adc_hs, out_hs, edge_t, done, frame_ok, go_cap, go_arm, abort;

  assign adc_unused = adc_axis_tlast;
  assign cmd_axis_tready = rdy;
  assign cmd_hs = cmd_axis_tvalid & rdy;
  assign len_new = LEN_W'({len_hi, cmd_axis_tdata});
  assign frame_ok = state == IDLE && cmd_hs && !drop && fcnt == 2'd2 && cmd_axis_tlast && len_new != '0;
  assign go_cap = frame_ok && opc == 8'h01;
  assign go_arm = frame_ok && opc == 8'h02;
  // abort only counts as a one-byte frame: fcnt tracks mid-frame bytes while armed
  assign abort = state == ARM && cmd_hs && cmd_axis_tlast && fcnt == 2'd0 && cmd_axis_tdata == 8'hFF;
  assign edge_t = trigger & ~trig_d;
  assign done = cnt == len;
  assign adc_axis_tready = rdy & (state != CAPTURE || (!done && (!out_axis_tvalid || out_axis_tready)));
  assign adc_hs = state == CAPTURE && adc_axis_tvalid && adc_axis_tready;
  assign out_hs = out_axis_tvalid & out_axis_tready;
  assign busy = state != IDLE;
  assign armed = state == ARM;

  always_ff @(posedge axi_aclk or posedge axi_areset)
    if (axi_areset) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = go_cap ? CAPTURE : go_arm ? ARM : IDLE;
    else if (state == ARM) state_nx = abort ? IDLE : edge_t ? CAPTURE : ARM;
    else if (out_hs && out_axis_tlast) state_nx = IDLE;
  end

  always_ff @(posedge axi_aclk or posedge axi_areset)
    if (axi_areset) begin
      rdy <= 1'b0;
      trig_d <= 1'b0;
      fcnt <= '0;
      drop <= 1'b0;
      opc <= '0;
      len_hi <= '0;
      len <= '0;
      cnt <= '0;
      out_axis_tvalid <= 1'b0;
      out_axis_tdata <= '0;
      out_axis_tlast <= 1'b0;
    end else begin
      rdy <= 1'b1;
      trig_d <= trigger;
      if (state == CAPTURE || state_nx != state) begin
        fcnt <= '0;
        drop <= 1'b0;
      end else if (cmd_hs) begin
        if (cmd_axis_tlast) begin
          fcnt <= '0;
          drop <= 1'b0;
        end else if (state == ARM) fcnt <= 2'd1;
        else if (!drop) begin
          fcnt <= fcnt == 2'd2 ? 2'd0 : fcnt + 2'd1;
          drop <= fcnt == 2'd2;
          if (fcnt == 2'd0) opc <= cmd_axis_tdata;
          if (fcnt == 2'd1) len_hi <= cmd_axis_tdata;
        end
      end
      if (frame_ok) len <= len_new;
      if (state != CAPTURE) cnt <= '0;
      else if (adc_hs) cnt <= cnt + LEN_W'(1);
      if (adc_hs) begin
        out_axis_tvalid <= 1'b1;
        out_axis_tdata <= adc_axis_tdata;
        out_axis_tlast <= cnt + LEN_W'(1) == len;
      end else if (out_hs) begin
        out_axis_tvalid <= 1'b0;
        out_axis_tlast <= 1'b0;
      end
    end
endmodule

// File: tb/tb_acq_ctrl.sv
// tb_acq_ctrl: directed scenarios with a scoreboard of expected capture beats and mode-based busy/armed checks.
module tb_acq_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_v = 0, cmd_r, cmd_l = 0, adc_v = 0, adc_r, adc_l = 0;
  logic out_v, out_r = 1, out_l, trigger = 0, busy, armed;
  logic [7:0] cmd_d = 0, adc_d = 0, out_d;
  int vec = 0, err = 0, m_mode = 0, arm_cnt = 0;
  bit m_rdy = 0, tog = 0;
  logic [8:0] exp_q[$], got_q[$];

  always #5 clk = ~clk;

  acq_ctrl #(.LEN_W(16)) dut (
    .axi_aclk(clk), .axi_areset(rst),
    .cmd_axis_tvalid(cmd_v), .cmd_axis_tready(cmd_r), .cmd_axis_tdata(cmd_d), .cmd_axis_tlast(cmd_l),
    .adc_axis_tvalid(adc_v), .adc_axis_tready(adc_r), .adc_axis_tdata(adc_d), .adc_axis_tlast(adc_l),
    .out_axis_tvalid(out_v), .out_axis_tready(out_r), .out_axis_tdata(out_d), .out_axis_tlast(out_l),
    .trigger(trigger), .busy(busy), .armed(armed)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    logic hs;
    @(negedge clk);
    hs = adc_v & adc_r;
    @(posedge clk);
    #1;
    if (hs) adc_d = adc_d + 8'd1;
    if (tog) out_r = ~out_r;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    cmd_v = 1; cmd_d = b; cmd_l = l;
    step();
    cmd_v = 0; cmd_l = 0; cmd_d = 0;
  endtask

  task automatic frame(input logic [7:0] op, input logic [7:0] hi, input logic [7:0] lo);
    send(op, 0); send(hi, 0); send(lo, 1);
  endtask

  task automatic expect_cap(input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, 8'(s + i)});
  endtask

  task automatic run_cap();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      step();
      n++;
    end
    chk("capture_complete", exp_q.size(), 0);
    m_mode = 0;
  endtask

  // per-cycle compare: mode-derived busy/armed, ready levels, AXI hold, scoreboard pops
  initial begin
    bit stall_p = 0;
    logic [9:0] stall_v = 0;
    forever begin
      @(negedge clk);
      chk("busy", busy, m_mode != 0);
      chk("armed", armed, m_mode == 1);
      if (armed === 1'b1) arm_cnt++;
      if (m_rdy) chk("cmd_tready", cmd_r, 1);
      if (m_rdy && m_mode != 2) chk("adc_tready_idle", adc_r, 1);
      if (stall_p && !rst) chk("stall_hold", {out_l, out_v, out_d}, stall_v);
      stall_p = out_v & !out_r & !rst;
      stall_v = {out_l, out_v, out_d};
      if (out_v === 1'b1 && out_r) begin
        if (exp_q.size() == 0) begin
          vec++;
          err++;
          $display("FAIL extra_beat: got %0h expected no beat at %0t", {out_l, out_d}, $time);
        end else chk("beat", {out_l, out_d}, exp_q.pop_front());
        got_q.push_back({out_l, out_d});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int g0, a0, n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_v, 0); chk("rst_out_data", out_d, 0); chk("rst_out_last", out_l, 0);
    chk("rst_busy", busy, 0); chk("rst_armed", armed, 0);
    chk("rst_cmd_tready", cmd_r, 0); chk("rst_adc_tready", adc_r, 0);
    rst = 0;
    #1 chk("cmd_tready_before_edge", cmd_r, 0);
    step();
    chk("cmd_tready_after_edge", cmd_r, 1); chk("adc_tready_after_edge", adc_r, 1);
    m_rdy = 1;
    // immediate capture of 4 samples from a ramp at 0x10
    g0 = got_q.size();
    frame(8'h01, 8'h00, 8'h04);
    m_mode = 2; adc_v = 1; adc_d = 8'h10;
    expect_cap(8'h10, 4);
    run_cap();
    chk("imm_count", got_q.size() - g0, 4);
    chk("imm_b0", got_q[g0], 9'h010); chk("imm_b1", got_q[g0+1], 9'h011);
    chk("imm_b2", got_q[g0+2], 9'h012); chk("imm_b3", got_q[g0+3], 9'h113);
    idle(2);
    // triggered capture: 20 armed cycles, then samples following the edge
    g0 = got_q.size();
    adc_d = 8'h80;
    frame(8'h02, 8'h00, 8'h02);
    m_mode = 1; a0 = arm_cnt;
    idle(19);
    trigger = 1;
    step();
    trigger = 0; m_mode = 2;
    expect_cap(adc_d, 2);
    chk("armed_cycles", arm_cnt - a0, 20);
    run_cap();
    chk("trig_b0", got_q[g0], 9'h097); chk("trig_b1", got_q[g0+1], 9'h198);
    idle(2);
    // triggered capture with out_tready toggling every cycle
    frame(8'h02, 8'h00, 8'h05);
    m_mode = 1;
    idle(3);
    tog = 1; trigger = 1;
    step();
    trigger = 0; m_mode = 2;
    expect_cap(adc_d, 5);
    run_cap();
    tog = 0; out_r = 1;
    idle(2);
    // malformed, unknown-opcode and zero-length frames, plus byte 3 without tlast
    g0 = got_q.size(); adc_v = 0;
    send(8'h01, 0); send(8'h00, 1);
    frame(8'h03, 8'h00, 8'h05);
    frame(8'h01, 8'h00, 8'h00);
    frame(8'h02, 8'h00, 8'h00);
    send(8'h01, 0); send(8'h00, 0); send(8'h02, 0);
    send(8'h01, 0); send(8'h00, 0); send(8'h03, 1);
    idle(4);
    chk("bad_frames_no_beats", got_q.size() - g0, 0);
    // level held high into ARM must not fire; non-single-byte 0xFF ignored; then abort
    trigger = 1;
    step();
    frame(8'h02, 8'h00, 8'h03);
    m_mode = 1;
    idle(4);
    send(8'h55, 1);
    send(8'hFF, 0); send(8'h00, 1);
    idle(2);
    send(8'hFF, 1);
    m_mode = 0; trigger = 0;
    idle(3);
    // abort and trigger edge in the same cycle: abort wins
    frame(8'h02, 8'h00, 8'h03);
    m_mode = 1;
    idle(3);
    trigger = 1;
    send(8'hFF, 1);
    m_mode = 0; trigger = 0;
    idle(4);
    chk("abort_no_beats", got_q.size() - g0, 0);
    // length using the high byte; command bytes during capture are ignored
    g0 = got_q.size();
    frame(8'h01, 8'h01, 8'h02);
    m_mode = 2; adc_v = 1; adc_d = 8'hF0;
    expect_cap(8'hF0, 258);
    send(8'h01, 0); send(8'h00, 0); send(8'h05, 1); send(8'hFF, 1);
    run_cap();
    chk("long_count", got_q.size() - g0, 258);
    chk("long_last", got_q[g0+257], 9'h1F1);
    idle(3);
    // reset during a capture, then a fresh one-beat capture
    adc_v = 0;
    frame(8'h01, 8'h00, 8'h08);
    m_mode = 2; adc_v = 1; adc_d = 8'h20;
    expect_cap(8'h20, 8);
    g0 = got_q.size(); n = 0;
    while (got_q.size() - g0 < 3 && n < 100) begin
      step();
      n++;
    end
    chk("beats_before_reset", got_q.size() - g0, 3);
    rst = 1; exp_q.delete(); m_mode = 0; m_rdy = 0;
    #1;
    chk("mid_rst_out_valid", out_v, 0); chk("mid_rst_out_data", out_d, 0); chk("mid_rst_out_last", out_l, 0);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_cmd_tready", cmd_r, 0); chk("mid_rst_adc_tready", adc_r, 0);
    @(posedge clk);
    #1 rst = 0;
    #1 chk("cmd_tready_post_rst", cmd_r, 0);
    step();
    m_rdy = 1;
    chk("cmd_tready_rise", cmd_r, 1);
    adc_v = 0;
    frame(8'h01, 8'h00, 8'h01);
    m_mode = 2; adc_v = 1; adc_d = 8'h40;
    expect_cap(8'h40, 1);
    g0 = got_q.size();
    run_cap();
    chk("post_rst_count", got_q.size() - g0, 1);
    chk("post_rst_beat", got_q[g0], 9'h140);
    idle(3);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
